// File: rtl/mem_bridge.sv
// mem_bridge
//   Turns a single core load/store request into one word-aligned valid/ready
//   bus transfer. It generates byte strobes and lane-replicated write data,
//   extracts and sign/zero-extends load data, and rejects misaligned or
//   reserved-size accesses without touching the bus. A bus that never answers
//   is abandoned after TIMEOUT cycles. Completion is a one-cycle core_ready
//   pulse, with core_fault and core_rdata valid in that cycle.
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   core_req       request present (sampled only while idle)
//   core_we        1 = store, 0 = load
//   core_size      00 byte, 01 half, 10 word, 11 reserved
//   core_unsigned  1 = zero-extend load data, 0 = sign-extend
//   core_addr      byte address
//   core_wdata     right-aligned store data
//   core_rdata     extended load data (valid with core_ready)
//   core_ready     one-cycle completion pulse
//   core_fault     access failed (valid with core_ready)
//   bus_valid      bus request, held until bus_ready or timeout
//   bus_we         bus write
//   bus_addr       word-aligned address
//   bus_wdata      lane-replicated store data
//   bus_wstrb      byte strobes, 0000 on loads
//   bus_ready      bus completes the transfer this cycle
//   bus_rdata      read word (valid with bus_ready)
//   bus_err        bus error (valid with bus_ready)
//
// All outputs come straight from registers.

module mem_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [1:0]  core_size,
  input  logic        core_unsigned,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_ready,
  output logic        core_fault,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Last counter value before the outstanding access is abandoned.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  // ---------------------------------------------------------------------------
  // Access decode helpers
  // ---------------------------------------------------------------------------
  function automatic logic is_illegal(input logic [1:0] size,
                                      input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] strobe_for(input logic [1:0] size,
                                            input logic [1:0] off);
    logic [3:0] s;
    s = 4'b0000;
    case (size)
      SZ_BYTE: s = 4'b0001 << off;
      SZ_HALF: s = off[1] ? 4'b1100 : 4'b0011;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] wdata_for(input logic [1:0]  size,
                                            input logic [31:0] wd);
    logic [31:0] w;
    w = wd;
    case (size)
      SZ_BYTE: w = {4{wd[7:0]}};
      SZ_HALF: w = {2{wd[15:0]}};
      default: w = wd;
    endcase
    return w;
  endfunction

  // Shifting the word right by the lane offset brings the addressed byte or
  // half down to bit 0, so extraction is a fixed slice afterwards.
  function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                               input logic        uns,
                                               input logic [1:0]  off,
                                               input logic [31:0] rd);
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    logic [31:0] r;
    sh_b = rd >> {off, 3'b000};
    sh_h = rd >> {off[1], 4'b0000};
    r    = rd;
    case (size)
      SZ_BYTE: r = {{24{~uns & sh_b[7]}}, sh_b[7:0]};
      SZ_HALF: r = {{16{~uns & sh_h[15]}}, sh_h[15:0]};
      default: r = rd;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  off_q, off_d;

  logic [31:0] core_rdata_q, core_rdata_d;
  logic        core_ready_q, core_ready_d;
  logic        core_fault_q, core_fault_d;
  logic        bus_valid_q, bus_valid_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;

  logic        req_illegal;
  assign req_illegal = is_illegal(core_size, core_addr[1:0]);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    core_rdata_d = core_rdata_q;
    core_ready_d = 1'b0;
    core_fault_d = core_fault_q;
    bus_valid_d  = bus_valid_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_wstrb_d  = bus_wstrb_q;

    unique case (state_q)
      IDLE: begin
        if (core_req) begin
          if (req_illegal) begin
            state_d      = DONE;
            core_ready_d = 1'b1;
            core_fault_d = 1'b1;
            core_rdata_d = '0;
          end else begin
            state_d     = ISSUE;
            cnt_d       = '0;
            size_d      = core_size;
            uns_d       = core_unsigned;
            off_d       = core_addr[1:0];
            bus_valid_d = 1'b1;
            bus_we_d    = core_we;
            bus_addr_d  = {core_addr[31:2], 2'b00};
            bus_wdata_d = wdata_for(core_size, core_wdata);
            bus_wstrb_d = core_we ? strobe_for(core_size, core_addr[1:0]) : 4'b0000;
          end
        end
      end

      ISSUE: begin
        // A response on the timeout cycle wins over the timeout.
        if (bus_ready) begin
          state_d      = DONE;
          bus_valid_d  = 1'b0;
          core_ready_d = 1'b1;
          core_fault_d = bus_err;
          if (bus_err || bus_we_q) begin
            core_rdata_d = '0;
          end else begin
            core_rdata_d = load_extract(size_q, uns_q, off_q, bus_rdata);
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d      = DONE;
          bus_valid_d  = 1'b0;
          core_ready_d = 1'b1;
          core_fault_d = 1'b1;
          core_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d     = IDLE;
        bus_valid_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      off_q        <= '0;
      core_rdata_q <= '0;
      core_ready_q <= 1'b0;
      core_fault_q <= 1'b0;
      bus_valid_q  <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_wstrb_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      core_rdata_q <= core_rdata_d;
      core_ready_q <= core_ready_d;
      core_fault_q <= core_fault_d;
      bus_valid_q  <= bus_valid_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_wstrb_q  <= bus_wstrb_d;
    end
  end

  assign core_rdata = core_rdata_q;
  assign core_ready = core_ready_q;
  assign core_fault = core_fault_q;
  assign bus_valid  = bus_valid_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_wstrb  = bus_wstrb_q;

endmodule
